// File: rtl/sim_monitor.sv
// sim_monitor: simulation-side watcher for a CPU test program on the data bus.
// Buffers console bytes, tracks per-channel result matches, and reports a
// terminal pass / fail / timeout status.
//
// Ports:
//   clk, reset              single clock, synchronous active-high reset
//   MemWrite/DataAdr/WriteData   observed bus write
//   char_valid/char_ready/char_data  console byte stream (valid/ready)
//   pass_mask               sticky per-channel pass flags
//   status, done            00 run/drain, 01 pass, 10 fail, 11 timeout
//   overflow                sticky console-drop flag
//   cycle_count             cycles spent in RUN/DRAIN
module sim_monitor #(
    parameter int                DW          = 32,
    parameter logic [DW-1:0]     CONSOLE_ADR = 32'h1000_0000,
    parameter logic [DW-1:0]     RESULT_ADR  = 100,
    parameter int                NCH         = 2,
    parameter logic [NCH*DW-1:0] PASS_VAL    = {32'd7, 32'd25},
    parameter bit                FAIL_EN     = 1'b0,
    parameter int                FIFO_DEPTH  = 8,
    parameter int                TIMEOUT     = 1000,
    parameter int                DRAIN       = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           MemWrite,
    input  logic [DW-1:0]  DataAdr,
    input  logic [DW-1:0]  WriteData,
    output logic           char_valid,
    input  logic           char_ready,
    output logic [7:0]     char_data,
    output logic [NCH-1:0] pass_mask,
    output logic [1:0]     status,
    output logic           done,
    output logic           overflow,
    output logic [31:0]    cycle_count
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int DCW = $clog2(DRAIN + 1);

    typedef enum logic [2:0] {
        S_RUN,
        S_DRAIN,
        S_PASS,
        S_FAIL,
        S_TMO
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [NCH-1:0] mask_d;
    logic [NCH-1:0] match;
    logic [NCH-1:0] hit;
    logic [DCW-1:0] drain_cnt;
    logic           res_wr;
    logic           con_wr;
    logic           active;

    // Bus decode
    assign res_wr = MemWrite && (DataAdr == RESULT_ADR);
    assign con_wr = MemWrite && (DataAdr == CONSOLE_ADR);
    assign active = (state_q == S_RUN) || (state_q == S_DRAIN);

    always_comb begin
        match = '0;
        for (int i = 0; i < NCH; i++) begin
            match[i] = (WriteData == PASS_VAL[i*DW +: DW]);
        end
    end

    assign hit = res_wr ? match : '0;

    // Next state and status outputs
    always_comb begin
        state_d = state_q;
        mask_d  = pass_mask;
        status  = 2'b00;
        done    = 1'b0;
        unique case (state_q)
            S_RUN: begin
                if (FAIL_EN && res_wr && (hit == '0)) begin
                    state_d = S_FAIL;
                end else begin
                    mask_d = pass_mask | hit;
                    if (&mask_d) begin
                        state_d = S_DRAIN;
                    end else if (cycle_count == 32'(TIMEOUT - 1)) begin
                        state_d = S_TMO;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_cnt == DCW'(DRAIN - 1)) begin
                    state_d = S_PASS;
                end
            end
            S_PASS: begin
                status = 2'b01;
                done   = 1'b1;
            end
            S_FAIL: begin
                status = 2'b10;
                done   = 1'b1;
            end
            S_TMO: begin
                status = 2'b11;
                done   = 1'b1;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pass_mask   <= '0;
            cycle_count <= '0;
            drain_cnt   <= '0;
        end else begin
            pass_mask <= mask_d;
            if (active) begin
                cycle_count <= cycle_count + 32'd1;
            end
            // Counts cycles already spent in DRAIN; zero on entry
            if (state_q == S_DRAIN) begin
                drain_cnt <= drain_cnt + 1'b1;
            end else begin
                drain_cnt <= '0;
            end
        end
    end

    // Console FIFO: extra pointer bit separates full from empty
    logic [7:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        empty;
    logic        full;
    logic        push;
    logic        pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                   (wr_ptr[AW] != rd_ptr[AW]);

    assign char_valid = !empty;
    assign pop        = char_valid && char_ready;
    // A full FIFO still takes a byte when a slot frees in the same cycle
    assign push       = con_wr && (!full || pop);
    assign char_data  = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (con_wr && !push) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[wr_ptr[AW-1:0]] <= WriteData[7:0];
        end
    end

endmodule

// File: tb/tb_sim_monitor.sv
// tb_sim_monitor: randomized and directed bench for sim_monitor.
// Two instances (fail-enabled/short-timeout and default) share one bus.
module tb_sim_monitor;

    localparam logic [31:0] CON = 32'h1000_0000;
    localparam logic [31:0] RES = 32'd100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemWrite = 1'b0;
    logic [31:0] DataAdr = '0;
    logic [31:0] WriteData = '0;
    logic        char_ready = 1'b0;

    logic        a_valid, b_valid;
    logic [7:0]  a_data, b_data;
    logic [1:0]  a_mask, b_mask;
    logic [1:0]  a_status, b_status;
    logic        a_done, b_done;
    logic        a_ovf, b_ovf;
    logic [31:0] a_cc, b_cc;

    always #5 clk = ~clk;

    sim_monitor #(.FAIL_EN(1'b1), .TIMEOUT(20)) u_a (
        .clk(clk), .reset(reset), .MemWrite(MemWrite),
        .DataAdr(DataAdr), .WriteData(WriteData),
        .char_valid(a_valid), .char_ready(char_ready),
        .char_data(a_data), .pass_mask(a_mask), .status(a_status),
        .done(a_done), .overflow(a_ovf), .cycle_count(a_cc)
    );

    sim_monitor u_b (
        .clk(clk), .reset(reset), .MemWrite(MemWrite),
        .DataAdr(DataAdr), .WriteData(WriteData),
        .char_valid(b_valid), .char_ready(char_ready),
        .char_data(b_data), .pass_mask(b_mask), .status(b_status),
        .done(b_done), .overflow(b_ovf), .cycle_count(b_cc)
    );

    int tests = 0;
    int fails = 0;

    // Reference model. States: 0 RUN, 1 DRAIN, 2 PASS, 3 FAIL, 4 TIMEOUT
    int  st[2];
    int  msk[2];
    int  cnt[2];
    int  dc[2];
    int  tmo[2] = '{20, 1000};
    bit  fen[2] = '{1'b1, 1'b0};
    int  occ = 0;
    bit  ovf = 1'b0;
    byte unsigned expq[$];
    bit  mon_en = 1'b0;

    function automatic logic [1:0] stat(int s);
        case (s)
            2: return 2'b01;
            3: return 2'b10;
            4: return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", n, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit rs;
        bit cw;
        bit pop;
        int m;
        int old;
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                st[i] = 0; msk[i] = 0; cnt[i] = 0; dc[i] = 0;
            end
            occ = 0;
            ovf = 1'b0;
            expq.delete();
        end else begin
            rs = MemWrite && (DataAdr == RES);
            cw = MemWrite && (DataAdr == CON);
            m = 0;
            if (rs && WriteData == 32'd25) m |= 1;
            if (rs && WriteData == 32'd7) m |= 2;
            for (int i = 0; i < 2; i++) begin
                case (st[i])
                    0: begin
                        old = cnt[i];
                        cnt[i]++;
                        if (rs && m == 0 && fen[i]) begin
                            st[i] = 3;
                        end else begin
                            msk[i] |= m;
                            if (msk[i] == 3) begin
                                st[i] = 1;
                                dc[i] = 0;
                            end else if (old == tmo[i] - 1) begin
                                st[i] = 4;
                            end
                        end
                    end
                    1: begin
                        cnt[i]++;
                        dc[i]++;
                        if (dc[i] == 4) st[i] = 2;
                    end
                    default: ;
                endcase
            end
            pop = (occ > 0) && char_ready;
            if (cw) begin
                if (occ < 8 || pop) begin
                    occ++;
                    expq.push_back(WriteData[7:0]);
                end else begin
                    ovf = 1'b1;
                end
            end
            if (pop) occ--;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(int n);
        repeat (n) cyc();
    endtask

    task automatic wr(logic [31:0] a, logic [31:0] d);
        MemWrite = 1'b1;
        DataAdr = a;
        WriteData = d;
        cyc();
        MemWrite = 1'b0;
        DataAdr = '0;
        WriteData = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    // Monitor: compares outputs to the model, pops console scoreboard
    always @(negedge clk) begin
        if (mon_en) begin
            chk("a_status", a_status, stat(st[0]));
            chk("a_done", a_done, st[0] >= 2);
            chk("a_mask", a_mask, msk[0]);
            chk("a_count", a_cc, cnt[0]);
            chk("a_ovf", a_ovf, ovf);
            chk("a_valid", a_valid, occ > 0);
            chk("b_status", b_status, stat(st[1]));
            chk("b_mask", b_mask, msk[1]);
            chk("b_count", b_cc, cnt[1]);
            if (a_valid && expq.size() > 0) begin
                chk("a_data", a_data, expq[0]);
                if (char_ready) void'(expq.pop_front());
            end
        end
    end

    initial begin
        cyc();
        do_reset();
        mon_en = 1'b1;
        chk("rst_status", a_status, 0);
        chk("rst_mask", a_mask, 0);
        chk("rst_data", a_data, 0);
        chk("rst_count", a_cc, 0);

        // Console
        char_ready = 1'b1;
        wr(CON, 32'h48);
        chk("con_v1", a_valid, 1);
        chk("con_d1", a_data, 8'h48);
        wr(CON, 32'h69);
        chk("con_d2", a_data, 8'h69);
        cyc();
        chk("con_v3", a_valid, 0);
        idle(2);

        // Backpressure
        do_reset();
        char_ready = 1'b0;
        for (int i = 0; i < 9; i++) wr(CON, 32'h41 + i);
        chk("bp_ovf", a_ovf, 1);
        chk("bp_head", a_data, 8'h41);
        char_ready = 1'b1;
        idle(10);
        chk("bp_empty", a_valid, 0);

        // Pass
        do_reset();
        wr(RES, 7);
        chk("pass_m1", a_mask, 2'b10);
        wr(RES, 25);
        chk("pass_m2", a_mask, 2'b11);
        chk("pass_s0", a_status, 0);
        idle(3);
        chk("pass_s3", b_status, 0);
        chk("pass_d3", a_done, 0);
        cyc();
        chk("pass_st", a_status, 2'b01);
        chk("pass_dn", b_done, 1);

        // Fail (u_a) / ignore (u_b)
        do_reset();
        wr(RES, 3);
        chk("fail_st", a_status, 2'b10);
        chk("fail_dn", a_done, 1);
        chk("fail_m", a_mask, 0);
        chk("ign_st", b_status, 0);
        wr(RES, 7);
        chk("fail_m2", a_mask, 0);
        chk("ign_m2", b_mask, 2'b10);

        // Timeout on u_a (TIMEOUT=20)
        do_reset();
        idle(19);
        chk("tmo_pre", a_status, 0);
        cyc();
        chk("tmo_st", a_status, 2'b11);
        chk("tmo_cc", a_cc, 20);
        idle(5);
        chk("tmo_frz", a_cc, 20);

        // Reset mid-DRAIN with buffered bytes
        do_reset();
        char_ready = 1'b0;
        wr(CON, 32'h31);
        wr(CON, 32'h32);
        wr(CON, 32'h33);
        wr(RES, 7);
        wr(RES, 25);
        cyc();
        do_reset();
        chk("mr_status", b_status, 0);
        chk("mr_mask", b_mask, 0);
        chk("mr_valid", a_valid, 0);
        chk("mr_count", b_cc, 0);
        char_ready = 1'b1;
        idle(3);

        // Randomized traffic
        for (int r = 0; r < 5; r++) begin
            do_reset();
            for (int c = 0; c < 200; c++) begin
                MemWrite = ($urandom_range(0, 9) < 5);
                case ($urandom_range(0, 2))
                    0: DataAdr = CON;
                    1: DataAdr = RES;
                    default: DataAdr = $urandom;
                endcase
                case ($urandom_range(0, 3))
                    0: WriteData = 32'd7;
                    1: WriteData = 32'd25;
                    2: WriteData = $urandom_range(0, 40);
                    default: WriteData = $urandom;
                endcase
                char_ready = ($urandom_range(0, 3) < r);
                reset = ($urandom_range(0, 99) == 0);
                cyc();
            end
            reset = 1'b0;
            MemWrite = 1'b0;
        end

        char_ready = 1'b1;
        idle(20);
        chk("final_drain", expq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sim_monitor.md
SIM_MONITOR -- requirements
Module: sim_monitor

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DW, 32, data/address width
- CONSOLE_ADR, 32'h1000_0000, console character address
- RESULT_ADR, 100, result/signature address
- NCH, 2, number of pass channels
- PASS_VAL, {32'd7, 32'd25}, packed NCH*DW; channel i value at [i*DW +: DW] (ch0=25, ch1=7)
- FAIL_EN, 0, 1 = unmatched result write means failure
- FIFO_DEPTH, 8, console FIFO entries (power of 2, >=2)
- TIMEOUT, 1000, run cycles before timeout
- DRAIN, 4, cycles from all-pass to done
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, the single clock; all logic on its rising edge
- reset, in, 1, synchronous active-high reset
- MemWrite, in, 1, bus write strobe
- DataAdr, in, DW, write address
- WriteData, in, DW, write data
- char_valid, out, 1, console byte available
- char_ready, in, 1, sink accepts byte
- char_data, out, 8, console byte
- pass_mask, out, NCH, sticky per-channel pass flags
- status, out, 2, 00 RUN, 01 PASS, 10 FAIL, 11 TIMEOUT
- done, out, 1, high in any terminal state
- overflow, out, 1, sticky console drop flag
- cycle_count, out, 32, cycles spent in RUN/DRAIN

Function
REQ-003 A bus write SHALL be sampled at a rising clk edge with MemWrite=1 and reset=0. DataAdr and WriteData SHALL be compared over the full DW bits.
REQ-004 A write to CONSOLE_ADR SHALL push WriteData[7:0] into the FIFO in every state, terminal states included.
REQ-005 A push SHALL be accepted if the FIFO is not full, or if a pop occurs in the same cycle. Otherwise the byte SHALL be dropped and overflow set until reset.
REQ-006 char_valid SHALL equal FIFO not-empty.
REQ-007 A pop SHALL occur when char_valid && char_ready.
REQ-008 char_data SHALL present the oldest byte and SHALL hold stable while char_valid && !char_ready.
REQ-009 A push into an empty FIFO SHALL make char_valid high the next cycle. There SHALL be no same-cycle bypass.
REQ-010 Pointers SHALL wrap modulo FIFO_DEPTH. Order SHALL be strict FIFO.
REQ-011 A write to RESULT_ADR SHALL be compared against every channel's PASS_VAL, in RUN only.
- Each match sets its pass_mask bit, sticky.
- Duplicate PASS_VAL entries all set.
- Rewriting an already-passed value has no further effect.
REQ-012 States SHALL be RUN (reset state), DRAIN, PASS, FAIL and TIMEOUT.
- status reports DRAIN as 00.
- done=0 in RUN and DRAIN.
REQ-013 RUN SHALL transition as follows, evaluated in this priority order in the same cycle:
- FAIL, on a RESULT_ADR write matching no channel while FAIL_EN=1.
- DRAIN, when pass_mask including bits set this cycle is all ones.
- TIMEOUT, when cycle_count==TIMEOUT-1.
REQ-014 A RESULT_ADR write matching no channel while FAIL_EN=0 SHALL be ignored.
REQ-015 DRAIN SHALL last exactly DRAIN cycles, then enter PASS.
- Timeout and result writes are ignored in DRAIN.
REQ-016 PASS, FAIL and TIMEOUT SHALL be terminal until reset.
REQ-017 cycle_count SHALL increment once per cycle in RUN and DRAIN. It SHALL freeze in terminal states.
REQ-018 Writes to any other address SHALL have no effect.

Reset
REQ-019 Reset SHALL set the following on the next edge, regardless of state:
- State = RUN; status=00; done=0
- pass_mask=0; overflow=0; cycle_count=0
- FIFO flushed; char_valid=0; char_data=0
REQ-020 Reset mid-operation SHALL discard buffered bytes and DRAIN progress. A bus write sampled while reset=1 SHALL be ignored.

Verification
REQ-021 The bench SHALL cover these scenarios:
- Console: write 0x48 then 0x69 to 32'h1000_0000, char_ready=1. Response: char_data 0x48 then 0x69, each valid one cycle, starting the cycle after the push.
- Backpressure: char_ready=0, 9 console writes 0x41..0x49 (DEPTH 8). Response: overflow=1; releasing char_ready yields exactly 0x41..0x48.
- Pass: write 7 to address 100, then 25 to address 100. Response: pass_mask 10 then 11; status 00 for 4 more cycles, then 01 with done=1.
- Fail (FAIL_EN=1): write 3 to address 100. Response: next cycle status=10, done=1, pass_mask unchanged.
- Timeout (TIMEOUT=20): no writes. Response: status=11 after the 20th RUN cycle; cycle_count frozen at 20.
- Reset mid-DRAIN with 3 buffered bytes. Response: status=00, pass_mask=0, char_valid=0 and cycle_count=0 the cycle after reset.
